// File: rtl/axi_interconnect_crossbar_req_sched_pkg.sv
// Shared crossbar definitions: channel-mode encodings, scheduler state
// encoding and the LOG2 width helper used to size index and counter fields.
package axi_interconnect_crossbar_req_sched_pkg;

  localparam bit MODE_RD = 1'b1;  // AR channel, no write-data steering
  localparam bit MODE_WR = 1'b0;  // AW/W channel, write-data queue present

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  // Bits needed to hold 'value' (minimum 1), so LOG2(3)=2 and LOG2(4)=3.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned bits;
    int unsigned rem;
    bits = 1;
    rem  = value >> 1;
    while (rem != 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_sel_fifo.sv
// Synchronous FIFO of source indices recording write-address grant order.
// Ports: clk_sys/rst (sync, active-high), push_i/push_data_i enqueue,
// pop_i dequeues, pop_data_o shows the head, full_o/empty_o flags.
// Push and pop in the same cycle are accepted even when full.
module axi_interconnect_crossbar_sel_fifo
  import axi_interconnect_crossbar_req_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = log2(DEPTH - 1);
  localparam int unsigned CNT_W = log2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push    = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi_interconnect_crossbar_req_sched.sv
// Request-path scheduler for one crossbar direction. Round-robin arbitrates
// NUM_SLAVE address requesters onto one shared channel, limits issued-but-
// unretired transactions to NUM_OUTSTANDING and, in write mode, steers W
// beats from sources in address-grant order.
// Ports: clk_sys/rst (sync, active-high); s_req_valid/s_req_ready per-source
// address handshake; m_req_valid/m_req_ready/m_req_sel shared address channel;
// s_wdata_valid/s_wdata_last/s_wdata_ready per-source W beats; m_wdata_valid/
// m_wdata_ready/m_wdata_sel shared W channel; resp_done retires one
// transaction; ost_cnt outstanding count; busy any work in flight.
module axi_interconnect_crossbar_req_sched
  import axi_interconnect_crossbar_req_sched_pkg::*;
#(
  parameter bit          MODE_READ       = MODE_RD,
  parameter int unsigned NUM_SLAVE       = 4,
  parameter int unsigned NUM_OUTSTANDING = 4,
  parameter int unsigned WIDTH_SALVE     = log2(NUM_SLAVE - 1),
  parameter int unsigned WIDTH_OST       = log2(NUM_OUTSTANDING)
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic [NUM_SLAVE-1:0]   s_req_valid,
  output logic [NUM_SLAVE-1:0]   s_req_ready,
  output logic                   m_req_valid,
  input  logic                   m_req_ready,
  output logic [WIDTH_SALVE-1:0] m_req_sel,
  input  logic [NUM_SLAVE-1:0]   s_wdata_valid,
  input  logic [NUM_SLAVE-1:0]   s_wdata_last,
  output logic [NUM_SLAVE-1:0]   s_wdata_ready,
  output logic                   m_wdata_valid,
  input  logic                   m_wdata_ready,
  output logic [WIDTH_SALVE-1:0] m_wdata_sel,
  input  logic                   resp_done,
  output logic [WIDTH_OST-1:0]   ost_cnt,
  output logic                   busy
);

  sched_state_e           state_q, state_d;
  logic [WIDTH_SALVE-1:0] sel_q, sel_d;
  logic [WIDTH_SALVE-1:0] last_q, last_d;
  logic [WIDTH_OST-1:0]   ost_q, ost_d;
  logic [WIDTH_SALVE-1:0] cand;
  logic [WIDTH_SALVE-1:0] pick_idx;
  logic                   pick_valid;
  logic                   can_issue;
  logic                   req_hs;
  logic                   resp_eff;
  logic                   q_full;
  logic                   q_empty;

  // Round-robin: first valid source after the last granted one.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_SLAVE; i++) begin
      cand = WIDTH_SALVE'((32'(last_q) + i) % NUM_SLAVE);
      if (!pick_valid && s_req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign can_issue = (ost_q < WIDTH_OST'(NUM_OUTSTANDING)) &&
                     ((MODE_READ == MODE_RD) || !q_full);

  // State register, including the grant index, priority pointer and credits.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= WIDTH_SALVE'(NUM_SLAVE - 1);
      ost_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ost_q   <= ost_d;
    end
  end

  // Next state: latch a winner in IDLE, hold it until the channel accepts.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && can_issue) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (m_req_ready) begin
          state_d = ST_IDLE;
          last_d  = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: only the granted source sees the channel's ready.
  always_comb begin
    m_req_valid = 1'b0;
    s_req_ready = '0;
    req_hs      = 1'b0;
    if (state_q == ST_GRANT) begin
      m_req_valid        = 1'b1;
      s_req_ready[sel_q] = m_req_ready;
      req_hs             = m_req_ready;
    end
  end

  // Credit counter; a retire against an empty count is dropped.
  always_comb begin
    ost_d    = ost_q;
    resp_eff = resp_done && (ost_q != '0);
    if (req_hs && !resp_eff)      ost_d = ost_q + WIDTH_OST'(1);
    else if (!req_hs && resp_eff) ost_d = ost_q - WIDTH_OST'(1);
  end

  assign m_req_sel = sel_q;
  assign ost_cnt   = ost_q;
  assign busy      = (ost_q != '0) || !q_empty;

  if (MODE_READ == MODE_WR) begin : g_wq
    logic [WIDTH_SALVE-1:0] fifo_head;
    logic [WIDTH_SALVE-1:0] q_head;
    logic                   q_pop;

    axi_interconnect_crossbar_sel_fifo #(
      .DEPTH (NUM_OUTSTANDING),
      .WIDTH (WIDTH_SALVE)
    ) u_sel_fifo (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .push_i      (req_hs),
      .push_data_i (sel_q),
      .pop_i       (q_pop),
      .pop_data_o  (fifo_head),
      .full_o      (q_full),
      .empty_o     (q_empty)
    );

    // Head of the grant-order queue owns the W channel until its last beat.
    assign q_head        = q_empty ? '0 : fifo_head;
    assign m_wdata_sel   = q_head;
    assign m_wdata_valid = !q_empty && s_wdata_valid[q_head];
    assign q_pop         = m_wdata_valid && m_wdata_ready && s_wdata_last[q_head];

    always_comb begin
      s_wdata_ready         = '0;
      s_wdata_ready[q_head] = !q_empty && m_wdata_ready;
    end
  end else begin : g_rd
    logic wdata_unused;
    assign wdata_unused  = ^{s_wdata_valid, s_wdata_last, m_wdata_ready};
    assign q_full        = 1'b0;
    assign q_empty       = 1'b1;
    assign m_wdata_sel   = '0;
    assign m_wdata_valid = 1'b0;
    assign s_wdata_ready = '0;
  end

endmodule
